maxpool_line_fifo: RTL and testbench

//  Parametrised synchronous FIFO that buffers max-pool feature rows between the pooling datapath and the

---
 rtl/maxpool_line_fifo.sv | 108 ++++++++++
 tb/tb_maxpool_line_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/maxpool_line_fifo.sv
// Synchronous FIFO for max-pool feature rows. It has an inferred RAM, a registered read port,
// programmable S/M ready thresholds, an occupancy count, a flush input and sticky error flags.
module maxpool_line_fifo #(
  parameter int WIDTH     = 128,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     din,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 empty,
  output logic                 full,
  output logic [ADDR_BITS:0]   data_count,
  input  logic [ADDR_BITS:0]   S_count,
  input  logic [ADDR_BITS:0]   M_count,
  output logic                 S_Ready,
  output logic                 M_Ready,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic [WIDTH-1:0]     dout_q;
  logic                 dout_valid_q, dout_valid_d;
  logic                 s_ready_q, s_ready_d;
  logic                 m_ready_q, m_ready_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 wr_acc, rd_acc;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_CNT);
  assign wr_acc = wr_en & ~full & ~clear;
  assign rd_acc = rd_en & ~empty & ~clear;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_valid_d = rd_acc;
    ovf_d        = ovf_q | (wr_en & full);
    udf_d        = udf_q | (rd_en & empty);
    // Flags are compared against the registered count, so they trail it by one cycle.
    s_ready_d    = (count_q < S_count);
    m_ready_d    = (count_q >= M_count);
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      dout_valid_d = 1'b0;
      ovf_d        = 1'b0;
      udf_d        = 1'b0;
    end
  end

  // The RAM array has no reset, so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      s_ready_q    <= 1'b1;
      m_ready_q    <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      s_ready_q    <= s_ready_d;
      m_ready_q    <= m_ready_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      if (rd_acc) dout_q <= mem[rd_ptr_q];
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign data_count = count_q;
  assign S_Ready    = s_ready_q;
  assign M_Ready    = m_ready_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
endmodule

// File: tb/tb_maxpool_line_fifo.sv
// Randomised bench for maxpool_line_fifo. It uses a queue-based reference model and a
// scoreboard of expected read words that a negedge monitor consumes.
module tb_maxpool_line_fifo;
  localparam int WIDTH = 128;
  localparam int AB    = 6;
  localparam int DEPTH = 2 ** AB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, empty, full, S_Ready, M_Ready, overflow, underflow;
  logic [AB:0]      data_count;
  logic [AB:0]      S_count = 7'd60;
  logic [AB:0]      M_count = 7'd16;

  int checks = 0;
  int errors = 0;

  maxpool_line_fifo #(.WIDTH(WIDTH), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full), .data_count(data_count),
    .S_count(S_count), .M_count(M_count), .S_Ready(S_Ready), .M_Ready(M_Ready),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue plus the expected flag and output values.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic m_dv = 0, m_sr = 1, m_mr = 0, m_ovf = 0, m_udf = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_q.delete(); sb_q.delete();
        m_dout = '0; m_dv = 0; m_sr = 1; m_mr = 0; m_ovf = 0; m_udf = 0;
      end else begin
        int c;
        c = model_q.size();
        m_sr = (c < int'(S_count));
        m_mr = (c >= int'(M_count));
        if (clear) begin
          model_q.delete();
          m_ovf = 0; m_udf = 0; m_dv = 0;
        end else begin
          m_dv = rd_en && (c > 0);
          if (rd_en && c > 0) begin
            m_dout = model_q.pop_front();
            sb_q.push_back(m_dout);
          end
          if (wr_en && c < DEPTH) model_q.push_back(din);
          if (wr_en && c == DEPTH) m_ovf = 1;
          if (rd_en && c == 0) m_udf = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("data_count", WIDTH'(data_count), WIDTH'(model_q.size()));
      check("empty", WIDTH'(empty), WIDTH'(model_q.size() == 0));
      check("full", WIDTH'(full), WIDTH'(model_q.size() == DEPTH));
      check("S_Ready", WIDTH'(S_Ready), WIDTH'(m_sr));
      check("M_Ready", WIDTH'(M_Ready), WIDTH'(m_mr));
      check("overflow", WIDTH'(overflow), WIDTH'(m_ovf));
      check("underflow", WIDTH'(underflow), WIDTH'(m_udf));
      check("dout_valid", WIDTH'(dout_valid), WIDTH'(m_dv));
      check("dout_hold", dout, m_dout);
      if (dout_valid) begin
        if (sb_q.size() == 0) check("sb_unexpected", WIDTH'(1), WIDTH'(0));
        else check("sb_dout", dout, sb_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic cl);
    @(negedge clk);
    wr_en = w; rd_en = r; din = d; clear = cl;
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n;
    // Hold reset for two cycles, then run random traffic and reset in the middle of it.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rnd(), 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wr_en = 0; rd_en = 0;
    @(negedge clk);
    check("reset_dout", dout, '0);
    check("reset_empty", WIDTH'(empty), WIDTH'(1));

    // Fill with 0..63, then make a 65th write that must be dropped.
    S_count = 7'd60; M_count = 7'd16;
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, 1'b0, WIDTH'(i), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("fill_count", WIDTH'(data_count), WIDTH'(64));
    check("fill_overflow", WIDTH'(overflow), WIDTH'(1));

    // Drain all 64 words, then issue one extra read that must underflow while dout holds 63.
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("drain_last", dout, WIDTH'(63));
    check("drain_underflow", WIDTH'(underflow), WIDTH'(1));

    // Run concurrent reads and writes at a steady occupancy of 5 so the pointers wrap.
    cyc(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, rnd(), 1'b0);
    for (int i = 0; i < 200; i++) cyc(1'b1, 1'b1, rnd(), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("wrap_count", WIDTH'(data_count), WIDTH'(5));

    // Get 30 words stored with overflow set, then clear together with a write request.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, rnd(), 1'b0);
    for (int i = 0; i < 34; i++) cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, rnd(), 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    check("clear_count", WIDTH'(data_count), WIDTH'(0));
    check("clear_overflow", WIDTH'(overflow), WIDTH'(0));

    // Boundary thresholds: M_count=0 while empty, and S_count=65 while full.
    M_count = 7'd0; S_count = 7'd65;
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
    check("edge_mready_empty", WIDTH'(M_Ready), WIDTH'(1));
    for (int i = 0; i < DEPTH + 4; i++) cyc(1'b1, 1'b0, rnd(), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("edge_sready_full", WIDTH'(S_Ready), WIDTH'(1));
    check("edge_full", WIDTH'(full), WIDTH'(1));

    // Long random traffic with occasional clears and threshold changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        S_count = 7'($urandom_range(0, 70));
        M_count = 7'($urandom_range(0, 70));
      end
      n = $urandom_range(0, 9);
      cyc(n < (i % 400 < 200 ? 7 : 3), $urandom_range(0, 9) < (i % 400 < 200 ? 3 : 7), rnd(),
          $urandom_range(0, 299) == 0);
    end
    cyc(1'b0, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("sb_drained", WIDTH'(sb_q.size()), WIDTH'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
